// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, default bus widths, PC step and reset address.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int PC_STEP    = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Control-unit / instruction-memory bundle seen by the fetch unit.
// The slave modport is the fetch unit's view; master is the surrounding CPU.
interface inst_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              fetchStart;
  logic [ADDR_W-1:0] pcAddress;
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memAck;
  logic [DATA_W-1:0] memRdata;
  logic [DATA_W-1:0] instOut;
  logic [ADDR_W-1:0] pcPlus4;
  logic              fetchDone;
  logic              busy;
  logic              fault;

  modport slave (
    input  fetchStart, pcAddress, memAck, memRdata,
    output memReq, memAddr, instOut, pcPlus4, fetchDone, busy, fault
  );

  modport master (
    output fetchStart, pcAddress, memAck, memRdata,
    input  memReq, memAddr, instOut, pcPlus4, fetchDone, busy, fault
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait counter for an outstanding memory request; only built with FETCH_TIMEOUT_EN.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
)(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Fires on the edge that would complete the TIMEOUT_CYCLES-th idle wait cycle.
  assign expire_o = inc_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule
`endif

// File: rtl/inst_fetch_unit.sv
// IF stage: one instruction-memory read per fetchStart, result latched into the IR.
// Optional memAck timeout is enabled by defining FETCH_TIMEOUT_EN.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
)(
  input  logic              CLK,
  input  logic              RST,
  inst_fetch_unit_if.slave  bus
);
  fetch_state_e      state_q;
  logic              mem_req_q;
  logic              fetch_done_q;
  logic              busy_q;
  logic              fault_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] pc_plus4_q;
  logic [DATA_W-1:0] inst_q;

  logic start_ok;
  logic start_bad;
  logic timeout_hit;

  assign start_ok  = (state_q == ST_IDLE) && bus.fetchStart && (bus.pcAddress[1:0] == 2'b00);
  assign start_bad = (state_q == ST_IDLE) && bus.fetchStart && (bus.pcAddress[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (CLK),
    .rst      (RST),
    .clr_i    (start_ok),
    .inc_i    ((state_q == ST_REQ) && !bus.memAck),
    .expire_o (timeout_hit)
  );
`else
  logic unused_cfg;
  assign unused_cfg  = (TIMEOUT_CYCLES == 0);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      fetch_done_q <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      mem_addr_q   <= ADDR_W'(RESET_ADDR);
      pc_plus4_q   <= '0;
      inst_q       <= '0;
    end else begin
      fetch_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            mem_addr_q <= bus.pcAddress;
            pc_plus4_q <= bus.pcAddress + ADDR_W'(PC_STEP);
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            fault_q    <= 1'b0;
            state_q    <= ST_REQ;
          end else if (start_bad) begin
            fault_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_ERR;
          end
        end
        ST_REQ: begin
          // An ack wins over a timeout landing on the same edge.
          if (bus.memAck) begin
            inst_q       <= bus.memRdata;
            mem_req_q    <= 1'b0;
            fetch_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            fault_q   <= 1'b1;
            state_q   <= ST_ERR;
          end
        end
        ST_DONE, ST_ERR: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.memReq    = mem_req_q;
  assign bus.memAddr   = mem_addr_q;
  assign bus.instOut   = inst_q;
  assign bus.pcPlus4   = pc_plus4_q;
  assign bus.fetchDone = fetch_done_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Consumer side of the program-counter interface in the multicycle CPU.
- Takes the current PC address and runs one instruction-memory read per fetch request over a req/ack handshake.
- Latches the returned word into the instruction register (IR) and hands a completion pulse plus PC+4 back to the control unit.
- Sits between the PC, instruction memory and the control-unit FSM (IF stage).

Parameters:
- ADDR_W, 32, width of PC/memory address
- DATA_W, 32, width of instruction word
- TIMEOUT_CYCLES, 16, max wait cycles for memAck (used only with the optional feature)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- fetchStart  in  1  one-cycle request from control unit to begin a fetch
- pcAddress  in  ADDR_W  current PC value, sampled on the accepted fetchStart edge
- memReq  out  1  read request to instruction memory
- memAddr  out  ADDR_W  read address, stable while memReq=1
- memAck  in  1  memory response valid; memRdata valid in the same cycle
- memRdata  in  DATA_W  instruction word from memory
- instOut  out  DATA_W  instruction register contents
- pcPlus4  out  ADDR_W  registered sampled PC + 4
- fetchDone  out  1  one-cycle pulse: instOut/pcPlus4 updated
- busy  out  1  high in any state other than IDLE
- fault  out  1  sticky error flag: misalignment, or timeout with the optional feature

Behaviour:
- Reset values (asynchronous RST=1):
  - state=IDLE
  - memReq=0, memAddr=0, instOut=0, pcPlus4=0
  - fetchDone=0, busy=0, fault=0
  - RST asserted mid-fetch aborts immediately: memReq drops asynchronously and the outstanding memAck is ignored.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - fetchStart=1 and pcAddress[1:0]==0 → REQ. Register memAddr=pcAddress and pcPlus4=pcAddress+4; pcPlus4 wraps modulo 2^ADDR_W (0xFFFFFFFC → 0x00000000).
  - fetchStart=1 and pcAddress[1:0]!=0 → ERR. Set fault=1; memReq stays 0.
- REQ:
  - memReq=1 and memAddr held stable.
  - On the first edge where memAck=1: instOut←memRdata, memReq←0, → DONE.
  - An ack in the first REQ cycle is legal, giving minimum latency: fetchStart at edge N, memReq high in cycle N..N+1, ack sampled at edge N+1, fetchDone high during cycle N+1..N+2.
- DONE: fetchDone=1 for exactly one cycle → IDLE.
- ERR: one cycle → IDLE. fault remains set until the next accepted fetchStart with aligned address, which clears it.
- fetchStart while busy=1 is ignored: not queued, no effect on memAddr.
- memAck while memReq=0 is ignored; instOut is unchanged.
- instOut holds its value between fetches; it changes only on an accepted ack.
- Back-to-back: fetchStart may be asserted in the cycle fetchDone=1. It is ignored because the unit is still busy; the earliest accepted restart is the following cycle in IDLE.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to REQ and increments each REQ cycle without memAck.
  - When it reaches TIMEOUT_CYCLES: memReq←0, fault←1, → ERR; instOut is unchanged.
  - A late memAck afterwards is ignored.
- Not defined: no counter; REQ waits indefinitely for memAck.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2, ERR=2'd3)
  - ADDR_W/DATA_W defaults
  - PC_STEP constant (4)
  - reset address constant (32'h00000000)
- Sub-module: fetch_timeout_ctr, the wait counter with clear/inc/expire signals. Instantiate it only under FETCH_TIMEOUT_EN.
- The rest is a single FSM plus datapath registers.

Test Plan:
- Reset then idle: RST pulse → all outputs 0, busy=0. memAck=1 while idle → instOut stays 0.
- Single fetch: pcAddress=0x00000010, fetchStart pulse, memAck after 3 wait cycles with memRdata=0x8C220004 → memAddr=0x10 stable throughout, instOut=0x8C220004, pcPlus4=0x14, fetchDone exactly 1 cycle.
- Zero-wait ack plus ignored start: memAck held high, fetchStart at edge N → fetchDone in cycle N+1..N+2. A second fetchStart during busy with pcAddress=0x40 → ignored, memAddr stays the first value.
- Misaligned: pcAddress=0x00000006 → memReq never rises, fault=1. Next aligned fetch at 0x8 → fault clears, normal completion.
- Wrap and mid-fetch reset:
  - pcAddress=0xFFFFFFFC → pcPlus4=0x00000000.
  - Separately, RST asserted while memReq=1 → memReq drops with no clock edge, state=IDLE, instOut=0.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=4: no memAck → memReq drops after 4 REQ cycles, fault=1, instOut unchanged. A late memAck is ignored.
